spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on SCLK, SDI and nCS.
REQ-003 The block SHALL have port Clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port SCLK, input, 1 bit: serial clock from the master, idle high.
REQ-006 The block SHALL have port SDI, input, 1 bit: serial data from the master, MSB first.
REQ-007 The block SHALL have port nCS, input, 1 bit: chip select, active low.
REQ-008 The block SHALL have port TxData, input, DATA_WIDTH bits: response word, captured at frame start.
REQ-009 The block SHALL have port SDO, output, 1 bit: serial response data, MSB first.
REQ-010 The block SHALL have port RxData, output, DATA_WIDTH bits: last good received word.
REQ-011 The block SHALL have port RxValid, output, 1 bit: one-cycle pulse when RxData updates.
REQ-012 The block SHALL have port FrameError, output, 1 bit: one-cycle pulse on a short or long frame.
REQ-013 The block SHALL have port Busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-014 The block SHALL pass SCLK, SDI and nCS each through SYNC_STAGES flip-flops, plus one delay register for edge detection.
- Sync reset values: SCLK 1, nCS 1, SDI 0.
REQ-015 Inputs SHALL be treated as valid only if every SCLK high phase, SCLK low phase and nCS high phase lasts at least SYNC_STAGES+1 Clk periods.
- Behaviour outside this bound is undefined.
REQ-016 The state machine SHALL have states IDLE, RECEIVE and WAIT_CS; encoding is free.
REQ-017 IDLE:
- A synchronized nCS falling edge SHALL go to RECEIVE.
- BitCount SHALL clear to 0.
- TxShift SHALL load TxData.
- SDO SHALL take TxData[DATA_WIDTH-1] in the same cycle.
REQ-018 RECEIVE, synchronized SCLK falling edge:
- RxShift SHALL become {RxShift[DATA_WIDTH-2:0], SDI_sync}.
- BitCount SHALL increment.
REQ-019 RECEIVE, synchronized SCLK rising edge with BitCount>0:
- TxShift SHALL shift left by one.
- SDO SHALL take the new MSB.
- This matches a master that launches data with SCLK high and samples on SCLK falling.
REQ-020 RECEIVE SHALL move to WAIT_CS in the cycle BitCount reaches DATA_WIDTH.
REQ-021 WAIT_CS:
- Further SCLK falling edges SHALL set an internal Overrun flag and SHALL NOT change RxShift.
- SDO SHALL be driven 0.
REQ-022 Synchronized nCS rising edge in WAIT_CS:
- If Overrun is 0: RxData SHALL load RxShift and RxValid SHALL pulse high for one cycle.
- If Overrun is 1: FrameError SHALL pulse and RxData SHALL hold.
- In both cases the state SHALL return to IDLE.
REQ-023 Synchronized nCS rising edge in RECEIVE (BitCount<DATA_WIDTH) SHALL pulse FrameError for one cycle, hold RxData, and return to IDLE.
REQ-024 RxValid and FrameError SHALL never be high in the same cycle.
REQ-025 Each SHALL assert exactly one Clk cycle after the cycle in which the synchronized nCS rising edge is detected.
REQ-026 If SCLK and nCS edges are detected in the same cycle, the nCS edge SHALL take priority and the SCLK edge SHALL be ignored.
REQ-027 BitCount SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL never wrap within a frame.
REQ-028 SDO SHALL be 0 whenever the state is IDLE.
REQ-029 Busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-030 Asserting reset_n low SHALL immediately set:
- state IDLE;
- RxData 0, RxValid 0, FrameError 0, SDO 0;
- RxShift 0, TxShift 0, BitCount 0, Overrun 0;
- synchronizers to their REQ-014 values.
REQ-031 Reset mid-frame SHALL discard the partial frame and SHALL produce no RxValid or FrameError pulse.
REQ-032 After reset release, the block SHALL ignore any frame whose nCS was already low, until a new nCS falling edge is detected.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Good frame: 16-bit frame 0xA5C3, SCLK phases 4 Clk each -> RxValid single pulse, RxData=0xA5C3, FrameError 0.
- Response path: TxData=0x1234 at nCS fall, 16 clocks -> SDO sampled on SCLK falls reads 0x1234 MSB first; SDO=0 after nCS rise.
- Short frame: 10 SCLK falls then nCS high -> FrameError pulse, RxData keeps previous 0xA5C3.
- Long frame: 17 SCLK falls, data 0xFFFF -> FrameError pulse, no RxValid, RxData unchanged.
- Reset mid-frame: reset_n low after 8 bits -> all outputs 0, no pulses; next good frame 0x0001 -> RxData=0x0001.
- Back-to-back frames: 0x8001 then 0x7FFE, nCS high 3 Clk between -> two RxValid pulses with the correct values.

Source files
------------

// File: rtl/spi_slave_rx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// SPI slave receiver with response path. The master keeps SCLK high when idle,
// launches data while SCLK is high and samples on the SCLK falling edge. The
// slave does the same: it samples SDI on synchronized SCLK falls and advances
// SDO on synchronized SCLK rises. A frame is exactly DATA_WIDTH bits, framed by
// nCS low. A frame that is too short or too long is reported and then dropped.
//
// Parameters
//   DATA_WIDTH   frame length in bits (>= 2)
//   SYNC_STAGES  synchronizer depth on SCLK, SDI and nCS (>= 1)
//
// Ports
//   Clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   SCLK        serial clock from master, idle high
//   SDI         serial data from master, MSB first
//   nCS         chip select, active low
//   TxData      response word, captured when the frame starts
//   SDO         serial response data, MSB first, 0 outside a frame
//   RxData      last good received word
//   RxValid     one-cycle pulse when RxData updates
//   FrameError  one-cycle pulse on a short or long frame
//   Busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  SCLK,
  input  logic                  SDI,
  input  logic                  nCS,
  input  logic [DATA_WIDTH-1:0] TxData,
  output logic                  SDO,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  RxValid,
  output logic                  FrameError,
  output logic                  Busy
);

  localparam int unsigned     CntW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReceive,
    StWaitCs
  } stateT;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit 0 samples the pin, bit SYNC_STAGES-1 is the
  // synchronized value, and for SCLK/nCS bit SYNC_STAGES is the delayed copy
  // used for edge detection.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES:0]   sclkPipe;
  logic [SYNC_STAGES:0]   csPipe;
  logic [SYNC_STAGES-1:0] sdiPipe;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sclkPipe <= '1;
      csPipe   <= '1;
      sdiPipe  <= '0;
    end else begin
      sclkPipe <= {sclkPipe[SYNC_STAGES-1:0], SCLK};
      csPipe   <= {csPipe[SYNC_STAGES-1:0], nCS};
      sdiPipe[0] <= SDI;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sdiPipe[i] <= sdiPipe[i-1];
      end
    end
  end

  logic sclkSync, sclkDly, csSync, csDly, sdiSync;
  logic sclkFall, sclkRise, csFall, csRise;

  assign sclkSync = sclkPipe[SYNC_STAGES-1];
  assign sclkDly  = sclkPipe[SYNC_STAGES];
  assign csSync   = csPipe[SYNC_STAGES-1];
  assign csDly    = csPipe[SYNC_STAGES];
  assign sdiSync  = sdiPipe[SYNC_STAGES-1];

  assign sclkFall = sclkDly & ~sclkSync;
  assign sclkRise = ~sclkDly & sclkSync;
  assign csFall   = csDly & ~csSync;
  assign csRise   = ~csDly & csSync;

  // ---------------------------------------------------------------------------
  // Frame-start arming. The nCS synchronizer resets to 1, so a chip select that
  // is already low when reset releases would otherwise look like a fresh
  // falling edge. Starts are only accepted once nCS has actually been seen high
  // at the pin after reset. csPrimed skips the first cycle, in which bit 0 of
  // the pipe still holds its reset value rather than a real pin sample.
  // ---------------------------------------------------------------------------
  logic csPrimed;
  logic csArmed;
  logic csStart;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      csPrimed <= 1'b0;
      csArmed  <= 1'b0;
    end else begin
      csPrimed <= 1'b1;
      csArmed  <= csArmed | (csPrimed & csPipe[0]);
    end
  end

  assign csStart = csFall & csArmed;

  // ---------------------------------------------------------------------------
  // Frame state machine with registered outputs.
  // nCS edges are tested before SCLK edges, so a coincident SCLK edge is
  // dropped.
  // ---------------------------------------------------------------------------
  stateT                 state;
  logic [DATA_WIDTH-1:0] rxShift;
  logic [DATA_WIDTH-1:0] txShift;
  logic [CntW-1:0]       bitCount;
  logic                  overrun;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      rxShift    <= '0;
      txShift    <= '0;
      bitCount   <= '0;
      overrun    <= 1'b0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      FrameError <= 1'b0;
      SDO        <= 1'b0;
    end else begin
      RxValid    <= 1'b0;
      FrameError <= 1'b0;

      unique case (state)
        StIdle: begin
          SDO <= 1'b0;
          if (csStart) begin
            state    <= StReceive;
            bitCount <= '0;
            overrun  <= 1'b0;
            txShift  <= TxData;
            // First response bit must be on the wire before the first SCLK fall.
            SDO      <= TxData[DATA_WIDTH-1];
          end
        end

        StReceive: begin
          if (csRise) begin
            // Chip select released before a full word arrived.
            FrameError <= 1'b1;
            SDO        <= 1'b0;
            state      <= StIdle;
          end else if (sclkFall) begin
            rxShift  <= {rxShift[DATA_WIDTH-2:0], sdiSync};
            bitCount <= bitCount + 1'b1;
            if (bitCount == LastBit) begin
              state <= StWaitCs;
              SDO   <= 1'b0;
            end
          end else if (sclkRise && (bitCount != '0)) begin
            // The MSB is presented at frame start, so only rises that follow
            // a sampled bit advance the response.
            txShift <= {txShift[DATA_WIDTH-2:0], 1'b0};
            SDO     <= txShift[DATA_WIDTH-2];
          end
        end

        StWaitCs: begin
          SDO <= 1'b0;
          if (csRise) begin
            if (overrun) begin
              FrameError <= 1'b1;
            end else begin
              RxData  <= rxShift;
              RxValid <= 1'b1;
            end
            state <= StIdle;
          end else if (sclkFall) begin
            // Extra clocks past a full word make the frame invalid.
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= StIdle;
          SDO   <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = (state != StIdle);

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns / 1ps
// Self-checking bench for spi_slave_rx: directed frame table, hand-written
// reset sequences and randomized frames against a frame-level reference model.
module tb_spi_slave_rx;

  localparam int W  = 16;
  localparam int SS = 2;

  logic         Clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         SCLK    = 1'b1;
  logic         SDI     = 1'b0;
  logic         nCS     = 1'b1;
  logic [W-1:0] TxData  = '0;
  logic         SDO;
  logic [W-1:0] RxData;
  logic         RxValid;
  logic         FrameError;
  logic         Busy;

  always #5 Clk = ~Clk;

  spi_slave_rx #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(SS)
  ) dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .SCLK      (SCLK),
    .SDI       (SDI),
    .nCS       (nCS),
    .TxData    (TxData),
    .SDO       (SDO),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .FrameError(FrameError),
    .Busy      (Busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected outcome of each completed frame, in order.
  typedef struct packed {
    logic         isValid;
    logic [W-1:0] data;
  } evT;

  evT           expQ[$];
  logic [W-1:0] goodWord = '0;

  // Pulse monitor: every RxValid/FrameError pulse must match the next expected
  // frame outcome; pulses with nothing expected are failures.
  always @(negedge Clk) begin
    if (reset_n && (RxValid || FrameError)) begin
      evT ev;
      check("valid/error exclusive", 32'(RxValid & FrameError), 32'd0);
      if (expQ.size() == 0) begin
        check("unexpected pulse", {30'd0, RxValid, FrameError}, 32'd0);
      end else begin
        ev = expQ.pop_front();
        check("pulse RxValid", 32'(RxValid), 32'(ev.isValid));
        check("pulse FrameError", 32'(FrameError), 32'(!ev.isValid));
        check("RxData at pulse", 32'(RxData), 32'(ev.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // SDO seen at each SCLK fall: TxData MSB first, 0 once a full word is done.
  function automatic logic [31:0] expectedSdo(input logic [W-1:0] tx, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], (i < W) ? tx[W-1-i] : 1'b0};
    end
    return w;
  endfunction

  // Drive one frame: nFalls SCLK falls carrying bits[nFalls-1:0] MSB first.
  task automatic sendFrame(input logic [31:0] bits, input int nFalls, input logic [W-1:0] tx,
                           input int phase, input int gap, input logic expValid,
                           input logic [W-1:0] expData);
    logic [31:0] sdoCap = '0;
    evT          ev;
    TxData = tx;
    SCLK   = 1'b1;
    SDI    = (nFalls > 0) ? bits[nFalls-1] : 1'b0;
    nCS    = 1'b0;
    tick(phase);
    TxData = ~tx;  // must not affect the response already captured
    for (int i = 0; i < nFalls; i++) begin
      sdoCap = {sdoCap[30:0], SDO};
      SCLK   = 1'b0;
      tick(phase);
      if (i == 0) check("Busy mid-frame", 32'(Busy), 32'd1);
      SCLK = 1'b1;
      SDI  = (i + 1 < nFalls) ? bits[nFalls-2-i] : 1'b0;
      tick(phase);
    end
    check("SDO word", sdoCap, expectedSdo(tx, nFalls));
    ev.isValid = expValid;
    ev.data    = expData;
    expQ.push_back(ev);
    nCS = 1'b1;
    tick(gap);
  endtask

  task automatic settle(input logic [W-1:0] expRx);
    tick(10);
    check("pulses drained", 32'(expQ.size()), 32'd0);
    check("idle Busy", 32'(Busy), 32'd0);
    check("idle SDO", 32'(SDO), 32'd0);
    check("idle RxData", 32'(RxData), 32'(expRx));
  endtask

  typedef struct {
    logic [31:0] bits;
    int          nFalls;
    logic [W-1:0] tx;
    int          phase;
    int          gap;
    logic        doSettle;
    logic        expValid;
    logic [W-1:0] expRx;
  } vecT;

  vecT vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              bits        n   tx       ph gap settle valid rx
    vecs[0] = '{32'h0000A5C3, 16, 16'h0000, 4, 4, 1'b1, 1'b1, 16'hA5C3};  // good frame
    vecs[1] = '{32'h0000A5C3, 16, 16'h1234, 4, 4, 1'b1, 1'b1, 16'hA5C3};  // response path
    vecs[2] = '{32'h000003FF, 10, 16'hBEEF, 4, 4, 1'b1, 1'b0, 16'hA5C3};  // short frame
    vecs[3] = '{32'h0001FFFF, 17, 16'hFFFF, 4, 4, 1'b1, 1'b0, 16'hA5C3};  // long frame
    vecs[4] = '{32'h00008001, 16, 16'h0F0F, 4, 3, 1'b0, 1'b1, 16'h8001};  // back-to-back 1
    vecs[5] = '{32'h00007FFE, 16, 16'hF0F0, 4, 4, 1'b1, 1'b1, 16'h7FFE};  // back-to-back 2
    vecs[6] = '{32'h00000F0F, 16, 16'hC33C, 3, 3, 1'b1, 1'b1, 16'h0F0F};  // minimum phases

    // Reset state
    tick(3);
    check("reset RxData", 32'(RxData), 32'd0);
    check("reset RxValid", 32'(RxValid), 32'd0);
    check("reset FrameError", 32'(FrameError), 32'd0);
    check("reset SDO", 32'(SDO), 32'd0);
    check("reset Busy", 32'(Busy), 32'd0);
    reset_n = 1'b1;
    tick(4);

    foreach (vecs[k]) begin
      sendFrame(vecs[k].bits, vecs[k].nFalls, vecs[k].tx, vecs[k].phase, vecs[k].gap,
                vecs[k].expValid, vecs[k].expRx);
      if (vecs[k].doSettle) settle(vecs[k].expRx);
    end
    goodWord = 16'h0F0F;

    // Reset mid-frame: 8 bits in, then reset with nCS still low.
    TxData = 16'hFFFF;
    SDI    = 1'b1;
    nCS    = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      tick(4);
      SCLK = 1'b1;
      tick(4);
    end
    check("Busy before reset", 32'(Busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid-reset RxData", 32'(RxData), 32'd0);
    check("mid-reset SDO", 32'(SDO), 32'd0);
    check("mid-reset Busy", 32'(Busy), 32'd0);
    check("mid-reset RxValid", 32'(RxValid), 32'd0);
    check("mid-reset FrameError", 32'(FrameError), 32'd0);
    tick(3);
    goodWord = '0;

    // Release reset while nCS is still low: that frame must be ignored.
    reset_n = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b0;
      tick(4);
      check("ignored frame Busy", 32'(Busy), 32'd0);
      SCLK = 1'b1;
      tick(4);
    end
    nCS = 1'b1;
    settle(16'h0000);

    sendFrame(32'h00000001, 16, 16'h8421, 4, 4, 1'b1, 16'h0001);
    settle(16'h0001);
    goodWord = 16'h0001;

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 24; f++) begin
      logic [31:0]  bits;
      logic [W-1:0] tx;
      int           n;
      logic         ok;
      logic [W-1:0] expRx;
      bits  = $urandom;
      tx    = W'($urandom);
      n     = W - 2 + int'($urandom_range(0, 3));
      ok    = (n == W);
      expRx = ok ? bits[W-1:0] : goodWord;
      sendFrame(bits, n, tx, int'($urandom_range(3, 6)), int'($urandom_range(3, 6)), ok, expRx);
      goodWord = expRx;
      if (f % 6 == 5) settle(goodWord);
    end
    settle(goodWord);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
